// File: rtl/prog_clk_divider.sv
// Programmable clock divider: counts 0..D-1 and produces a registered divided clock,
// a terminal-count flag and a quadrature output when DIV_QUAD_OUT_EN is defined.
// Latency: outputs register one edge after the count; new divisors take effect at the next wrap.
// Backpressure: none; en freezes the count, and divisor loads are accepted every cycle.
module prog_clk_divider #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 4
) (
    input  logic             cp,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             clk_out,
    output logic             tc,
    output logic [WIDTH-1:0] cnt
`ifdef DIV_QUAD_OUT_EN
    ,
    output logic             clk_q
`endif
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_out_q, clk_out_d;
    logic             div_ack_q, div_ack_d;
    logic             div_err_q, div_err_d;
    logic             wrap;
    logic             load_ok;
    logic [WIDTH-1:0] high_start;
`ifdef DIV_QUAD_OUT_EN
    logic             clk_q_q, clk_q_d;
    logic [WIDTH:0]   quad_sum;
    logic [WIDTH:0]   quad_phase;
`endif

    // Next-state: count/wrap, pending divisor handling, and output phases from the next count.
    always_comb begin
        wrap       = en && (cnt_q == div_q - ONE);
        load_ok    = div_load && (div_in >= MIN_DIV);
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        div_ack_d  = 1'b0;
        div_err_d  = div_load && !load_ok;

        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
        end

        // The divisor swaps only at a wrap so every clk_out phase stays whole.
        if (wrap && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            div_ack_d  = 1'b1;
        end

        // A load on the wrap edge itself lands in pending and waits for the next wrap.
        if (load_ok) begin
            pend_d     = div_in;
            pend_vld_d = 1'b1;
        end

        // Low for ceil(D/2) counts, high for floor(D/2) counts.
        high_start = div_d - (div_d >> 1);
        clk_out_d  = (cnt_d >= high_start);

`ifdef DIV_QUAD_OUT_EN
        // Same waveform shifted early by floor(D/4) counts, wrapped modulo D.
        quad_sum   = {1'b0, cnt_d} + {1'b0, (div_d >> 2)};
        quad_phase = (quad_sum >= {1'b0, div_d}) ? (quad_sum - {1'b0, div_d}) : quad_sum;
        clk_q_d    = (quad_phase >= {1'b0, high_start});
`endif
    end

    // State registers with synchronous active-low reset; reset drops any pending load.
    always_ff @(posedge cp) begin
        if (!rst) begin
            cnt_q      <= '0;
            div_q      <= RST_DIV;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_out_q  <= 1'b0;
            div_ack_q  <= 1'b0;
            div_err_q  <= 1'b0;
`ifdef DIV_QUAD_OUT_EN
            clk_q_q    <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_out_q  <= clk_out_d;
            div_ack_q  <= div_ack_d;
            div_err_q  <= div_err_d;
`ifdef DIV_QUAD_OUT_EN
            clk_q_q    <= clk_q_d;
`endif
        end
    end

    assign cnt     = cnt_q;
    assign clk_out = clk_out_q;
    assign div_ack = div_ack_q;
    assign div_err = div_err_q;
    assign tc      = wrap;
`ifdef DIV_QUAD_OUT_EN
    assign clk_q   = clk_q_q;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed vectors push expected outputs into a queue,
// a monitor pops one entry per edge and compares. clk_q is checked when DIV_QUAD_OUT_EN is defined.
// Defaults WIDTH=8, RESET_DIV=4.
module tb_prog_clk_divider;

    logic       cp;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       div_ack;
    logic       div_err;
    logic       clk_out;
    logic       tc;
    logic [7:0] cnt;
`ifdef DIV_QUAD_OUT_EN
    logic       clk_q;
`endif

    prog_clk_divider #(.WIDTH(8), .RESET_DIV(4)) dut (
        .cp       (cp),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .clk_out  (clk_out),
        .tc       (tc),
        .cnt      (cnt)
`ifdef DIV_QUAD_OUT_EN
        ,
        .clk_q    (clk_q)
`endif
    );

    typedef struct {
        int   row;
        logic [7:0] cnt;
        logic co;
        logic tc;
        logic ack;
        logic err;
        logic cq;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   row_no = 0;

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
        end
    endtask

    // Drive one edge worth of inputs and queue the outputs expected after that edge.
    task automatic step(input bit r, input bit e, input bit l, input int d,
                        input int c, input bit co, input bit t, input bit a,
                        input bit er, input bit cq);
        exp_t x;
        @(negedge cp);
        rst      = r;
        en       = e;
        div_load = l;
        div_in   = 8'(d);
        x.row = row_no;
        x.cnt = 8'(c);
        x.co  = co;
        x.tc  = t;
        x.ack = a;
        x.err = er;
        x.cq  = cq;
        exp_q.push_back(x);
        row_no++;
        @(posedge cp);
    endtask

    // Monitor: after each edge, compare DUT outputs to the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge cp);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt",     e.row, cnt,            e.cnt);
                chk("clk_out", e.row, {7'd0, clk_out}, {7'd0, e.co});
                chk("tc",      e.row, {7'd0, tc},      {7'd0, e.tc});
                chk("div_ack", e.row, {7'd0, div_ack}, {7'd0, e.ack});
                chk("div_err", e.row, {7'd0, div_err}, {7'd0, e.err});
`ifdef DIV_QUAD_OUT_EN
                chk("clk_q",   e.row, {7'd0, clk_q},   {7'd0, e.cq});
`endif
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; div_load = 1'b0; div_in = 8'd0;

        // Reset wins over en and div_load.
        step(0,1,1,6, 0,0,0,0,0,0);
        step(0,1,0,0, 0,0,0,0,0,0);

        // D=4 free run, 12 edges.
        for (int k = 0; k < 3; k++) begin
            step(1,1,0,0, 1,0,0,0,0,1);
            step(1,1,0,0, 2,1,0,0,0,1);
            step(1,1,0,0, 3,1,1,0,0,0);
            step(1,1,0,0, 0,0,0,0,0,0);
        end

        // Load 5 at cnt=1; takes effect at the cnt=3 wrap.
        step(1,1,0,0, 1,0,0,0,0,1);
        step(1,1,1,5, 2,1,0,0,0,1);
        step(1,1,0,0, 3,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,1,0,0);
        step(1,1,0,0, 1,0,0,0,0,0);
        step(1,1,0,0, 2,0,0,0,0,1);
        step(1,1,0,0, 3,1,0,0,0,1);
        step(1,1,0,0, 4,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,0,0,0);

        // Illegal loads 1 and 0: err pulses, D stays 5, no ack.
        step(1,1,1,1, 1,0,0,0,1,0);
        step(1,1,1,0, 2,0,0,0,1,1);
        step(1,1,0,0, 3,1,0,0,0,1);
        step(1,1,0,0, 4,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,0,0,0);

        // Loads 6 then 3 before one wrap: last wins, single ack, D=3.
        step(1,1,1,6, 1,0,0,0,0,0);
        step(1,1,1,3, 2,0,0,0,0,1);
        step(1,1,0,0, 3,1,0,0,0,1);
        step(1,1,0,0, 4,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,1,0,0);
        step(1,1,0,0, 1,0,0,0,0,0);
        step(1,1,0,0, 2,1,1,0,0,1);
        // Load 4 on the wrap edge: D=3 for one more period.
        step(1,1,1,4, 0,0,0,0,0,0);
        step(1,1,0,0, 1,0,0,0,0,0);
        step(1,1,0,0, 2,1,1,0,0,1);
        step(1,1,0,0, 0,0,0,1,0,0);
        // D=4; reload same value still acks.
        step(1,1,0,0, 1,0,0,0,0,1);
        step(1,1,0,0, 2,1,0,0,0,1);
        step(1,1,1,4, 3,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,1,0,0);

        // Hold at cnt=2 for 5 edges with a load accepted while held.
        step(1,1,0,0, 1,0,0,0,0,1);
        step(1,1,0,0, 2,1,0,0,0,1);
        for (int k = 0; k < 5; k++) begin
            step(1,0,(k == 1),6, 2,1,0,0,0,1);
        end
        step(1,1,0,0, 3,1,1,0,0,0);
        // Reset on what would be the wrap edge: pending 6 dropped, no ack.
        step(0,1,0,0, 0,0,0,0,0,0);
        step(1,1,0,0, 1,0,0,0,0,1);
        step(1,1,0,0, 2,1,0,0,0,1);
        step(1,1,0,0, 3,1,1,0,0,0);
        step(1,0,0,0, 3,1,0,0,0,0);
        step(1,1,1,8, 0,0,0,0,0,0);
        step(1,1,0,0, 1,0,0,0,0,1);
        step(1,1,0,0, 2,1,0,0,0,1);
        step(1,1,0,0, 3,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,1,0,0);

        // D=8: clk_q leads clk_out by 2 counts.
        step(1,1,0,0, 1,0,0,0,0,0);
        step(1,1,0,0, 2,0,0,0,0,1);
        step(1,1,0,0, 3,0,0,0,0,1);
        step(1,1,0,0, 4,1,0,0,0,1);
        step(1,1,0,0, 5,1,0,0,0,1);
        step(1,1,0,0, 6,1,0,0,0,0);
        step(1,1,0,0, 7,1,1,0,0,0);
        step(1,1,0,0, 0,0,0,0,0,0);

        @(negedge cp);
        @(negedge cp);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
